// File: rtl/video_seq_pkg.sv
// video_seq_pkg
// Shared definitions for the video clock sequencer: state encoding, default
// timing constants and a small helper used to size the timing counter.
// No ports (package).
package video_seq_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_DIV_REL   = 3'd3;
    localparam logic [2:0] ST_SYS_REL   = 3'd4;
    localparam logic [2:0] ST_RUN       = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    // Default timing, in clk cycles
    localparam int unsigned DEF_PLL_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT      = 65535;
    localparam int unsigned DEF_SETTLE_CYCLES     = 1024;
    localparam int unsigned DEF_DIV_SETTLE_CYCLES = 64;
    localparam int unsigned DEF_MAX_RETRY         = 3;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk       - destination clock
//   ext_reset - asynchronous active-low reset, clears both flops
//   d         - asynchronous input
//   q         - synchronized output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic ext_reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_clk_sequencer.sv
// video_clk_sequencer
// Brings up the video PLL and the clock domains it feeds: pulses the PLL
// reset, waits for a stable lock, releases the 5x-to-1x divider, then the
// video pipeline. Retries on lock timeout and gives up (FAULT) after
// MAX_RETRY failed attempts. Lock loss after the divider is released sends
// the sequence back to PLL_RST.
// Optional feature: define VIDSEQ_LOSS_COUNT_EN to add loss_count.
// Ports:
//   clk         - free-running crystal clock
//   ext_reset   - asynchronous active-low reset
//   pll_lock    - raw PLL lock (asynchronous)
//   pll_reset   - active-high PLL reset (registered)
//   div_resetn  - active-low divider reset (registered)
//   sys_resetn  - active-low video pipeline reset (registered)
//   video_ready - high in RUN (registered)
//   fault       - high in FAULT (registered)
//   loss_count  - RUN lock-loss events, saturating at 255 (optional)
// Parameters must all be >= 1.
module video_clk_sequencer
    import video_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES    = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
    parameter int unsigned DIV_SETTLE_CYCLES = DEF_DIV_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRY         = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       ext_reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       div_resetn,
    output logic       sys_resetn,
    output logic       video_ready,
    output logic       fault
`ifdef VIDSEQ_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int unsigned MAX_T   = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES,
                                           DIV_SETTLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_T) + 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY) + 1;

    localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST     = CNT_W'(DIV_SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);

    logic               lock_s;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               run_loss;

    sync_2ff u_lock_sync (
        .clk       (clk),
        .ext_reset (ext_reset),
        .d         (pll_lock),
        .q         (lock_s)
    );

    // Both counters saturate so neither can wrap even if a parameter is odd.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        run_loss = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    // This timeout is attempt retry_q+1; give up once that
                    // reaches MAX_RETRY.
                    state_d = (retry_q >= RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE: begin
                // A glitch only restarts the settle window; not a retry.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DIV_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DIV_REL: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = ST_SYS_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SYS_REL: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    retry_d = retry_inc;
                end else begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = ST_PLL_RST;
                    run_loss = 1'b1;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register; div/sys drop on the very edge that leaves
    // a released state.
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset   <= 1'b1;
            div_resetn  <= 1'b0;
            sys_resetn  <= 1'b0;
            video_ready <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset   <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
            div_resetn  <= (state_d == ST_DIV_REL) || (state_d == ST_SYS_REL) ||
                           (state_d == ST_RUN);
            sys_resetn  <= (state_d == ST_SYS_REL) || (state_d == ST_RUN);
            video_ready <= (state_d == ST_RUN);
            fault       <= (state_d == ST_FAULT);
        end
    end

`ifdef VIDSEQ_LOSS_COUNT_EN
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            loss_count <= 8'd0;
        end else if (run_loss && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`else
    logic unused_run_loss;
    assign unused_run_loss = run_loss;
`endif

endmodule

// File: tb/tb_video_clk_sequencer.sv
// tb_video_clk_sequencer
// Self-checking bench for video_clk_sequencer with short timing parameters.
// A table of {inputs, hold cycles, expected outputs} walks the nominal
// bring-up and a lock loss in RUN; hand-written sequences cover timeout to
// FAULT, a settle glitch and ext_reset mid-sequence; a randomized phase
// compares every cycle against a behavioural model.
// Output bus order: {pll_reset, div_resetn, sys_resetn, video_ready, fault}.
module tb_video_clk_sequencer;

    localparam int unsigned PRC = 4;
    localparam int unsigned LT  = 100;
    localparam int unsigned SC  = 10;
    localparam int unsigned DSC = 5;
    localparam int unsigned MR  = 2;

    localparam logic [4:0] O_RST  = 5'b10000;
    localparam logic [4:0] O_WAIT = 5'b00000;
    localparam logic [4:0] O_DIV  = 5'b01000;
    localparam logic [4:0] O_SYS  = 5'b01100;
    localparam logic [4:0] O_RUN  = 5'b01110;
    localparam logic [4:0] O_FLT  = 5'b10001;

    logic clk = 1'b0;
    logic ext_reset;
    logic pll_lock;
    logic pll_reset, div_resetn, sys_resetn, video_ready, fault;
`ifdef VIDSEQ_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    always #5 clk = ~clk;

    video_clk_sequencer #(
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (LT),
        .SETTLE_CYCLES     (SC),
        .DIV_SETTLE_CYCLES (DSC),
        .MAX_RETRY         (MR)
    ) dut (
        .clk         (clk),
        .ext_reset   (ext_reset),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .div_resetn  (div_resetn),
        .sys_resetn  (sys_resetn),
        .video_ready (video_ready),
        .fault       (fault)
`ifdef VIDSEQ_LOSS_COUNT_EN
        ,
        .loss_count  (loss_count)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- behavioural model ----------------
    typedef enum int {M_PLL_RST, M_WAIT, M_SETTLE, M_DIV, M_SYS, M_RUN, M_FAULT} mphase_t;

    mphase_t     m_ph;
    int unsigned m_dwell;   // cycles already spent in the current phase
    int unsigned m_tries;   // failed attempts since last RUN
    int unsigned m_losses;
    bit          m_s1, m_s2;

    function automatic logic [4:0] m_out(input mphase_t ph);
        case (ph)
            M_PLL_RST:       return O_RST;
            M_WAIT, M_SETTLE: return O_WAIT;
            M_DIV:           return O_DIV;
            M_SYS:           return O_SYS;
            M_RUN:           return O_RUN;
            default:         return O_FLT;
        endcase
    endfunction

    task automatic mdl_reset();
        m_ph     = M_PLL_RST;
        m_dwell  = 0;
        m_tries  = 0;
        m_losses = 0;
        m_s1     = 1'b0;
        m_s2     = 1'b0;
    endtask

    task automatic enter(input mphase_t ph);
        m_ph    = ph;
        m_dwell = 0;
    endtask

    task automatic mdl_edge(input bit rst, input bit lock);
        bit ls;
        if (!rst) begin
            mdl_reset();
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            case (m_ph)
                M_PLL_RST: begin
                    m_dwell++;
                    if (m_dwell >= PRC) enter(M_WAIT);
                end
                M_WAIT: begin
                    if (ls) enter(M_SETTLE);
                    else begin
                        m_dwell++;
                        if (m_dwell >= LT) begin
                            m_tries++;
                            enter(m_tries >= MR ? M_FAULT : M_PLL_RST);
                        end
                    end
                end
                M_SETTLE: begin
                    if (!ls) enter(M_WAIT);
                    else begin
                        m_dwell++;
                        if (m_dwell >= SC) enter(M_DIV);
                    end
                end
                M_DIV: begin
                    if (!ls) begin
                        m_tries++;
                        enter(M_PLL_RST);
                    end else begin
                        m_dwell++;
                        if (m_dwell >= DSC) enter(M_SYS);
                    end
                end
                M_SYS: begin
                    if (!ls) begin
                        m_tries++;
                        enter(M_PLL_RST);
                    end else begin
                        m_tries = 0;
                        enter(M_RUN);
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        if (m_losses < 255) m_losses++;
                        enter(M_PLL_RST);
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- checking helpers ----------------
    function automatic logic [4:0] dut_bus();
        return {pll_reset, div_resetn, sys_resetn, video_ready, fault};
    endfunction

    task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: outputs %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: value %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Holds inputs for n edges, comparing the DUT to the model after each.
    task automatic drive(input bit rst, input bit lock, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ext_reset = rst;
            pll_lock  = lock;
            if (!rst) mdl_reset();
            @(posedge clk);
            mdl_edge(rst, lock);
            #1;
            check5("model", dut_bus(), m_out(m_ph));
            if (sys_resetn && !div_resetn)
                check5("sys_before_div", {3'b0, sys_resetn, div_resetn}, 5'b00001);
`ifdef VIDSEQ_LOSS_COUNT_EN
            check8("model_loss", loss_count, 8'(m_losses));
`endif
        end
    endtask

    // Asserts ext_reset between edges; outputs must react without a clock.
    task automatic pulse_reset();
        ext_reset = 1'b0;
        mdl_reset();
        #1;
        check5("rst_async", dut_bus(), O_RST);
    endtask

    typedef struct {
        bit          rst;
        bit          lock;
        int unsigned cycles;
        logic [4:0]  exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        ext_reset = 1'b0;
        pll_lock  = 1'b0;
        mdl_reset();

        // Nominal bring-up, lock high from edge 20, loss in RUN, relock.
        tbl[0]  = '{1'b0, 1'b0,  2, O_RST};
        tbl[1]  = '{1'b1, 1'b0,  3, O_RST};
        tbl[2]  = '{1'b1, 1'b0,  1, O_WAIT};
        tbl[3]  = '{1'b1, 1'b0, 15, O_WAIT};
        tbl[4]  = '{1'b1, 1'b1, 12, O_WAIT};
        tbl[5]  = '{1'b1, 1'b1,  1, O_DIV};
        tbl[6]  = '{1'b1, 1'b1,  4, O_DIV};
        tbl[7]  = '{1'b1, 1'b1,  1, O_SYS};
        tbl[8]  = '{1'b1, 1'b1,  1, O_RUN};
        tbl[9]  = '{1'b1, 1'b1, 10, O_RUN};
        tbl[10] = '{1'b1, 1'b0,  2, O_RUN};
        tbl[11] = '{1'b1, 1'b0,  1, O_RST};
        tbl[12] = '{1'b1, 1'b0,  3, O_RST};
        tbl[13] = '{1'b1, 1'b1,  1, O_WAIT};
        tbl[14] = '{1'b1, 1'b1, 12, O_DIV};
        tbl[15] = '{1'b1, 1'b1,  6, O_RUN};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].lock, tbl[i].cycles);
            check5($sformatf("row%0d", i), dut_bus(), tbl[i].exp);
        end
`ifdef VIDSEQ_LOSS_COUNT_EN
        check8("loss_after_run_drop", loss_count, 8'd1);
`endif

        // Lock never asserts: two PLL_RST pulses then FAULT, held.
        pulse_reset();
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 104);
        check5("retry_pll_rst", dut_bus(), O_RST);
        drive(1'b1, 1'b0, 3);
        check5("retry_pulse_len", dut_bus(), O_RST);
        drive(1'b1, 1'b0, 1);
        check5("retry_wait", dut_bus(), O_WAIT);
        drive(1'b1, 1'b0, 99);
        check5("pre_fault", dut_bus(), O_WAIT);
        drive(1'b1, 1'b0, 1);
        check5("fault", dut_bus(), O_FLT);
        drive(1'b1, 1'b1, 30);
        check5("fault_held", dut_bus(), O_FLT);
        pulse_reset();
        check5("fault_cleared", dut_bus(), O_RST);

        // One-cycle lock glitch during SETTLE restarts the settle window.
        drive(1'b0, 1'b1, 2);
        drive(1'b1, 1'b1, 7);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 7);
        check5("glitch_no_early_div", dut_bus(), O_WAIT);
        drive(1'b1, 1'b1, 5);
        check5("glitch_still_settle", dut_bus(), O_WAIT);
        drive(1'b1, 1'b1, 1);
        check5("glitch_div", dut_bus(), O_DIV);
        drive(1'b1, 1'b1, 2);
        check5("in_div_rel", dut_bus(), O_DIV);

        // ext_reset in DIV_REL: immediate reset, then the full sequence again.
        pulse_reset();
        drive(1'b0, 1'b1, 2);
        drive(1'b1, 1'b1, 14);
        check5("rerun_settle", dut_bus(), O_WAIT);
        drive(1'b1, 1'b1, 1);
        check5("rerun_div", dut_bus(), O_DIV);
        drive(1'b1, 1'b1, 5);
        check5("rerun_sys", dut_bus(), O_SYS);
        drive(1'b1, 1'b1, 1);
        check5("rerun_run", dut_bus(), O_RUN);

        // Randomized lock patterns against the model.
        for (int ep = 0; ep < 6; ep++) begin
            int unsigned spent;
            pulse_reset();
            drive(1'b0, 1'b0, 2);
            spent = 0;
            while (spent < 450) begin
                bit          v;
                int unsigned len;
                v = ($urandom_range(0, 3) != 0);
                if (v) len = $urandom_range(1, 60);
                else if ($urandom_range(0, 4) == 0) len = $urandom_range(90, 130);
                else len = $urandom_range(1, 12);
                if ($urandom_range(0, 29) == 0) begin
                    pulse_reset();
                    drive(1'b0, v, 1);
                end
                drive(1'b1, v, len);
                spent += len;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/video_clk_sequencer.md
VIDEO_CLK_SEQUENCER -- requirements
Module: video_clk_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: clk cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: clk cycles to wait for lock before retry.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024: cycles lock must stay continuously high before the divider is released.
REQ-004 SHALL have parameter DIV_SETTLE_CYCLES, default 64: cycles between divider release and system release.
REQ-005 SHALL have parameter MAX_RETRY, default 3: failed lock attempts tolerated before FAULT.
REQ-006 SHALL have port clk, input, 1: free-running crystal clock; all logic runs on it.
REQ-007 SHALL have port ext_reset, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port pll_lock, input, 1: raw PLL lock, asynchronous to clk.
REQ-009 SHALL have port pll_reset, output, 1: active-high PLL reset.
REQ-010 SHALL have port div_resetn, output, 1: active-low reset to the 5x-to-1x clock divider.
REQ-011 SHALL have port sys_resetn, output, 1: active-low reset to the video pipeline.
REQ-012 SHALL have port video_ready, output, 1: high only in RUN.
REQ-013 SHALL have port fault, output, 1: high only in FAULT.

Function
REQ-014 SHALL synchronize pll_lock through a 2-flop synchronizer; all decisions use the synchronized value lock_s.
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, SETTLE, DIV_REL, SYS_REL, RUN, FAULT.
REQ-016 PLL_RST: pll_reset=1, div_resetn=0, sys_resetn=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_reset=0; lock_s=1 -> SETTLE; LOCK_TIMEOUT cycles without lock -> retry_cnt+1 and PLL_RST, or FAULT if retry_cnt reaches MAX_RETRY.
REQ-018 SETTLE: lock_s=0 at any cycle -> restart the settle count in WAIT_LOCK, without a retry increment; SETTLE_CYCLES consecutive high cycles -> DIV_REL.
REQ-019 DIV_REL: div_resetn=1; after DIV_SETTLE_CYCLES -> SYS_REL.
REQ-020 SYS_REL: sys_resetn=1 for one cycle, then RUN; retry_cnt cleared on entry to RUN.
REQ-021 RUN: all three resets deasserted; lock_s=0 -> PLL_RST on next cycle, asserting div_resetn=0 and sys_resetn=0 in that same transition.
REQ-022 Lock loss in DIV_REL or SYS_REL SHALL behave as in RUN (-> PLL_RST), and SHALL count as a retry.
REQ-023 FAULT SHALL be terminal: pll_reset=1, div_resetn=0, sys_resetn=0, fault=1 until ext_reset.
REQ-024 All outputs SHALL be registered; sys_resetn SHALL never be 1 while div_resetn is 0.
REQ-025 Counters SHALL be sized with $clog2 of the largest timing parameter +1 and SHALL NOT wrap.

Reset
REQ-026 ext_reset low SHALL asynchronously force state PLL_RST with pll_reset=1, div_resetn=0, sys_resetn=0, video_ready=0, fault=0, counters 0, synchronizer 0.
REQ-027 Reset release SHALL be synchronous to clk via the state register; ext_reset mid-sequence restarts from PLL_RST.

Configuration
REQ-028 With VIDSEQ_LOSS_COUNT_EN defined, SHALL add output loss_count [7:0], incremented on every RUN -> PLL_RST transition and saturating at 255; cleared only by ext_reset.
REQ-029 Without VIDSEQ_LOSS_COUNT_EN, port loss_count and its register SHALL NOT exist.

Structure
REQ-030 State enum encoding and default timing constants SHALL live in shared package video_seq_pkg.
REQ-031 The pll_lock synchronizer SHALL be sub-module sync_2ff; the FSM and counters stay in video_clk_sequencer.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=10, DIV_SETTLE_CYCLES=5, MAX_RETRY=2)
REQ-032 Lock high from cycle 20 -> pll_reset falls at cycle 4, div_resetn rises ~12 cycles after lock_s, sys_resetn 5 cycles later, video_ready=1.
REQ-033 Lock never asserts -> two PLL_RST pulses of 4 cycles, then fault=1 at ~cycle 212, outputs held.
REQ-034 Lock glitches low for 1 cycle in SETTLE -> settle restarts, div_resetn delayed by 10+ cycles, retry_cnt unchanged.
REQ-035 Lock drops in RUN -> sys_resetn and div_resetn low next cycle, pll_reset high, loss_count=1 (macro on), recovery on relock.
REQ-036 ext_reset pulse in DIV_REL -> immediate div_resetn=0, full sequence repeats; ext_reset in FAULT clears fault.
